// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t           : loader FSM states
//   DEFAULT_SYNC_BYTE : frame start marker used when none is overridden
//   LEN_BYTES         : number of big-endian length bytes after the marker
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      DATA  = 3'd2,
      CSUM  = 3'd3,
      CHECK = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
   localparam int         LEN_BYTES         = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream valid/ready handshake feeding the loader.
//   in_data  : stream byte
//   in_valid : in_data is valid this cycle
//   in_ready : receiver accepts a byte this cycle
// A byte transfers on a rising edge where in_valid && in_ready.
//   master : producer (UART receiver, test driver)
//   slave  : consumer (imem_loader)
interface imem_loader_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/imem_loader_checksum.sv
// Running XOR of payload bytes.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the accumulator (start of a new frame)
//   en         : fold data into the accumulator
//   data       : payload byte
//   acc        : accumulated XOR, valid the cycle after the last enable
module imem_loader_checksum (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] acc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 8'h00;
      end else if (clr) begin
         acc <= 8'h00;
      end else if (en) begin
         acc <= acc ^ data;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into the byte-wide write port of the
// instruction memory and holds the core in reset until a frame with a
// good checksum has landed.
// Frame: SYNC_BYTE, LEN (4 bytes, MSB first), LEN payload bytes,
//        CSUM = XOR of the payload bytes.
//   clk, rst_n : clock, asynchronous active-low reset
//   strm       : byte stream input (slave side of the handshake)
//   mem_we     : memory write strobe, one cycle per accepted payload byte
//   mem_addr   : write address, BASE_ADDR + payload index
//   mem_wdata  : write data
//   load_done  : last frame loaded with a good checksum (sticky)
//   load_err   : last frame failed (sticky)
//   cpu_rst_n  : reset to the core, released only while load_done is high
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                         ADDRESS_WIDTH   = 32,
   parameter int                         PRACTICAL_WIDTH = 20,
   parameter int                         DATA_WIDTH      = 8,
   parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR       = '0,
   parameter logic [7:0]                 SYNC_BYTE       = DEFAULT_SYNC_BYTE
) (
   input  logic                      clk,
   input  logic                      rst_n,
   imem_loader_if.slave              strm,
   output logic                      mem_we,
   output logic [ADDRESS_WIDTH-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic                      load_done,
   output logic                      load_err,
   output logic                      cpu_rst_n
);

   // Largest legal payload: exactly 2**PRACTICAL_WIDTH bytes.
   localparam logic [32:0] LEN_CAP = 33'(1) << PRACTICAL_WIDTH;

   state_t                     state, state_nx;
   logic [31:0]                len, len_nx;
   logic [PRACTICAL_WIDTH:0]   cnt, cnt_nx;
   logic [1:0]                 len_idx, len_idx_nx;
   logic [7:0]                 csum, csum_nx;
   logic                       ready, ready_nx;
   logic                       we_nx;
   logic [ADDRESS_WIDTH-1:0]   addr_nx;
   logic [DATA_WIDTH-1:0]      wdata_nx;
   logic                       done_nx, err_nx, crst_nx;

   logic                       accept;
   logic                       is_sync;
   logic [31:0]                len_shift;
   logic                       xor_clr, xor_en;
   logic [7:0]                 xor_acc;

   assign strm.in_ready = ready;
   assign accept        = strm.in_valid && ready;
   assign is_sync       = (strm.in_data == SYNC_BYTE);
   assign len_shift     = (len << 8) | {24'h0, strm.in_data};

   imem_loader_checksum u_checksum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (xor_clr),
      .en    (xor_en),
      .data  (strm.in_data),
      .acc   (xor_acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         len       <= '0;
         cnt       <= '0;
         len_idx   <= '0;
         csum      <= '0;
         ready     <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         cpu_rst_n <= 1'b0;
      end else begin
         state     <= state_nx;
         len       <= len_nx;
         cnt       <= cnt_nx;
         len_idx   <= len_idx_nx;
         csum      <= csum_nx;
         ready     <= ready_nx;
         mem_we    <= we_nx;
         mem_addr  <= addr_nx;
         mem_wdata <= wdata_nx;
         load_done <= done_nx;
         load_err  <= err_nx;
         cpu_rst_n <= crst_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      len_nx     = len;
      cnt_nx     = cnt;
      len_idx_nx = len_idx;
      csum_nx    = csum;
      we_nx      = 1'b0;
      addr_nx    = mem_addr;
      wdata_nx   = mem_wdata;
      done_nx    = load_done;
      err_nx     = load_err;
      crst_nx    = cpu_rst_n;
      xor_clr    = 1'b0;
      xor_en     = 1'b0;

      case (state)
         // Outside a frame only the marker matters; everything else is
         // dropped without touching the sticky status.
         IDLE, DONE, ERR: begin
            if (accept && is_sync) begin
               state_nx   = LEN;
               len_nx     = '0;
               cnt_nx     = '0;
               len_idx_nx = '0;
               xor_clr    = 1'b1;
               done_nx    = 1'b0;
               err_nx     = 1'b0;
               crst_nx    = 1'b0;
            end
         end

         LEN: begin
            if (accept) begin
               len_nx     = len_shift;
               len_idx_nx = len_idx + 2'd1;
               if (len_idx == 2'(LEN_BYTES - 1)) begin
                  if ({1'b0, len_shift} > LEN_CAP) begin
                     state_nx = ERR;
                     err_nx   = 1'b1;
                  end else if (len_shift == 32'h0) begin
                     state_nx = CSUM;
                  end else begin
                     state_nx = DATA;
                  end
               end
            end
         end

         // The write is registered, so it appears on the port the cycle
         // after acceptance; back-to-back bytes give back-to-back writes.
         DATA: begin
            if (accept) begin
               we_nx    = 1'b1;
               addr_nx  = BASE_ADDR + ADDRESS_WIDTH'(cnt);
               wdata_nx = strm.in_data;
               cnt_nx   = cnt + 1'b1;
               xor_en   = 1'b1;
               if (32'(cnt_nx) == len) begin
                  state_nx = CSUM;
               end
            end
         end

         CSUM: begin
            if (accept) begin
               csum_nx  = strm.in_data;
               state_nx = CHECK;
            end
         end

         // xor_acc already includes the final payload byte here.
         CHECK: begin
            if (csum == xor_acc) begin
               state_nx = DONE;
               done_nx  = 1'b1;
               crst_nx  = 1'b1;
            end else begin
               state_nx = ERR;
               err_nx   = 1'b1;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      // Registered ready: low for exactly the single CHECK cycle.
      ready_nx = (state_nx != CHECK);
   end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        load_done;
   logic        load_err;
   logic        cpu_rst_n;

   imem_loader_if strm ();

   imem_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .strm      (strm),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .load_done (load_done),
      .load_err  (load_err),
      .cpu_rst_n (cpu_rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory array model written through the loader's port.
   logic [7:0] rom [0:255];
   always @(posedge clk) begin
      if (mem_we) rom[mem_addr[7:0]] <= mem_wdata;
   end

   // status nibble = {in_ready, load_done, load_err, cpu_rst_n}
   localparam logic [3:0] S_BUSY = 4'b1000;
   localparam logic [3:0] S_CHK  = 4'b0000;
   localparam logic [3:0] S_DONE = 4'b1101;
   localparam logic [3:0] S_ERR  = 4'b1010;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        we;
      logic [7:0]  a;
      logic [7:0]  w;
      logic [3:0]  st;
      logic        rom_chk;
      logic [31:0] rom_exp;
   } vec_t;

   vec_t tv[$];
   int   total = 0;
   int   passed = 0;

   task automatic add(input logic v, input logic [7:0] d, input logic we,
                      input logic [7:0] a, input logic [7:0] w, input logic [3:0] st);
      vec_t t;
      t.v = v; t.d = d; t.we = we; t.a = a; t.w = w; t.st = st;
      t.rom_chk = 1'b0; t.rom_exp = 32'h0;
      tv.push_back(t);
   endtask

   task automatic add_rom(input logic [31:0] exp);
      vec_t t;
      t = tv[tv.size()-1];
      t.rom_chk = 1'b1;
      t.rom_exp = exp;
      tv[tv.size()-1] = t;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      strm.in_valid = v;
      strm.in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input string tag);
      logic [44:0] act, exp;
      foreach (tv[i]) begin
         step(tv[i].v, tv[i].d);
         act = {mem_we, strm.in_ready, load_done, load_err, cpu_rst_n,
                tv[i].we ? mem_addr : 32'h0, tv[i].we ? mem_wdata : 8'h0};
         exp = {tv[i].we, tv[i].st,
                tv[i].we ? {24'h0, tv[i].a} : 32'h0, tv[i].we ? tv[i].w : 8'h0};
         chk($sformatf("%s row %0d", tag, i), 64'(act), 64'(exp));
         if (tv[i].rom_chk)
            chk($sformatf("%s rom row %0d", tag, i),
                64'({rom[0], rom[1], rom[2], rom[3]}), 64'(tv[i].rom_exp));
      end
      tv.delete();
   endtask

   task automatic chk_reset(input string name);
      chk(name,
          64'({mem_we, strm.in_ready, load_done, load_err, cpu_rst_n, mem_addr, mem_wdata}),
          64'({1'b0, S_BUSY, 32'h0, 8'h0}));
   endtask

   task automatic pulse_reset(input string name);
      #2 rst_n = 1'b0;
      #1 chk_reset(name);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b1;
      strm.in_valid = 1'b0;
      strm.in_data  = 8'h00;
      #2 rst_n = 1'b0;
      #1 chk_reset("initial reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Good 4-byte frame
      add(1, 8'hA5, 0, 0, 0, S_BUSY);
      for (int i = 0; i < 3; i++) add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h04, 0, 0, 0, S_BUSY);
      add(1, 8'h13, 1, 8'd0, 8'h13, S_BUSY);
      add(1, 8'h05, 1, 8'd1, 8'h05, S_BUSY);
      add(1, 8'h10, 1, 8'd2, 8'h10, S_BUSY);
      add(1, 8'h00, 1, 8'd3, 8'h00, S_BUSY);
      add(1, 8'h06, 0, 0, 0, S_CHK);
      add(0, 8'h00, 0, 0, 0, S_DONE);
      add_rom(32'h13051000);
      // Same frame, bad checksum; sync after DONE drops cpu_rst_n next cycle
      add(1, 8'hA5, 0, 0, 0, S_BUSY);
      for (int i = 0; i < 3; i++) add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h04, 0, 0, 0, S_BUSY);
      add(1, 8'h13, 1, 8'd0, 8'h13, S_BUSY);
      add(1, 8'h05, 1, 8'd1, 8'h05, S_BUSY);
      add(1, 8'h10, 1, 8'd2, 8'h10, S_BUSY);
      add(1, 8'h00, 1, 8'd3, 8'h00, S_BUSY);
      add(1, 8'h07, 0, 0, 0, S_CHK);
      add(0, 8'h00, 0, 0, 0, S_ERR);
      // Non-sync bytes ignored, then an empty frame
      add(1, 8'h00, 0, 0, 0, S_ERR);
      add(1, 8'hFF, 0, 0, 0, S_ERR);
      add(1, 8'hA5, 0, 0, 0, S_BUSY);
      for (int i = 0; i < 4; i++) add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h00, 0, 0, 0, S_CHK);
      add(0, 8'h00, 0, 0, 0, S_DONE);
      // Oversize length: 2**20 + 1
      add(1, 8'hA5, 0, 0, 0, S_BUSY);
      add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h10, 0, 0, 0, S_BUSY);
      add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h01, 0, 0, 0, S_ERR);
      add(1, 8'h13, 0, 0, 0, S_ERR);
      // Stalls inside DATA and CSUM
      add(1, 8'hA5, 0, 0, 0, S_BUSY);
      for (int i = 0; i < 3; i++) add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h03, 0, 0, 0, S_BUSY);
      add(1, 8'h11, 1, 8'd0, 8'h11, S_BUSY);
      add(0, 8'h99, 0, 0, 0, S_BUSY);
      add(1, 8'h22, 1, 8'd1, 8'h22, S_BUSY);
      add(0, 8'h99, 0, 0, 0, S_BUSY);
      add(1, 8'h33, 1, 8'd2, 8'h33, S_BUSY);
      add(0, 8'h55, 0, 0, 0, S_BUSY);
      add(1, 8'h00, 0, 0, 0, S_CHK);
      add(0, 8'h00, 0, 0, 0, S_DONE);
      // Sync byte value used as payload
      add(1, 8'hA5, 0, 0, 0, S_BUSY);
      for (int i = 0; i < 3; i++) add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h02, 0, 0, 0, S_BUSY);
      add(1, 8'hA5, 1, 8'd0, 8'hA5, S_BUSY);
      add(1, 8'h01, 1, 8'd1, 8'h01, S_BUSY);
      add(1, 8'hA4, 0, 0, 0, S_CHK);
      add(0, 8'h00, 0, 0, 0, S_DONE);
      add_rom(32'hA5013300);
      apply("table");

      // Reset while DONE releases nothing: cpu_rst_n drops immediately
      pulse_reset("reset in DONE");

      // Reset mid-payload after two bytes
      add(1, 8'hA5, 0, 0, 0, S_BUSY);
      for (int i = 0; i < 3; i++) add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h04, 0, 0, 0, S_BUSY);
      add(1, 8'h13, 1, 8'd0, 8'h13, S_BUSY);
      add(1, 8'h05, 1, 8'd1, 8'h05, S_BUSY);
      apply("partial");
      pulse_reset("reset mid frame");

      // Fresh frame after reset, with leading junk in IDLE
      add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'hFF, 0, 0, 0, S_BUSY);
      add(1, 8'hA5, 0, 0, 0, S_BUSY);
      for (int i = 0; i < 3; i++) add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h04, 0, 0, 0, S_BUSY);
      add(1, 8'hDE, 1, 8'd0, 8'hDE, S_BUSY);
      add(1, 8'hAD, 1, 8'd1, 8'hAD, S_BUSY);
      add(1, 8'hBE, 1, 8'd2, 8'hBE, S_BUSY);
      add(1, 8'hEF, 1, 8'd3, 8'hEF, S_BUSY);
      add(1, 8'h22, 0, 0, 0, S_CHK);
      add(0, 8'h00, 0, 0, 0, S_DONE);
      add_rom(32'hDEADBEEF);
      apply("reload");

      // Length of exactly 2**20 is accepted into DATA
      add(1, 8'hA5, 0, 0, 0, S_BUSY);
      add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h10, 0, 0, 0, S_BUSY);
      add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h00, 0, 0, 0, S_BUSY);
      add(1, 8'h77, 1, 8'd0, 8'h77, S_BUSY);
      add(0, 8'h00, 0, 0, 0, S_BUSY);
      apply("max len");
      pulse_reset("reset after max len");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
